chip8_sprite_draw: RTL

//  Executes CHIP-8 DXYN sprite draws: fetches N sprite bytes from main memory at I and

---
 rtl/chip8_sprite_draw.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   Executes the CHIP-8 DXYN instruction: reads N sprite bytes starting at I and XORs
//   each set sprite bit into the 64x32 monochrome framebuffer. It reports a collision
//   (VF) when any lit pixel is erased.
//
// Parameters
//   ADDR_W  memory address width; I+row wraps modulo 2**ADDR_W
//   WRAP    0: pixels past the right/bottom edge are clipped, 1: they wrap modulo 64/32
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start             draw request, only honoured while idle
//   vx, vy, n, i_addr sprite X/Y, height in rows, base address (latched at start)
//   busy              high whenever a draw is in progress (including the done cycle)
//   done              one-cycle completion pulse
//   collision         VF result, valid with done, held until the next accepted start
//   mem_rd, mem_addr  sprite byte read request; mem_rdata returns one cycle later
//   fb_x, fb_y        framebuffer pixel address; fb_rdata returns one cycle later
//   fb_write, fb_wdata framebuffer pixel write strobe and value

module chip8_sprite_draw #(
    parameter int ADDR_W = 12,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [5:0]        fb_x,
    output logic [4:0]        fb_y,
    input  logic              fb_rdata,
    output logic              fb_write,
    output logic              fb_wdata
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StPxRd,
        StPxWr,
        StDone
    } state_t;

    state_t            state;
    logic [5:0]        x0;
    logic [4:0]        y0;
    logic [3:0]        rows;
    logic [ADDR_W-1:0] base;
    logic [3:0]        row;
    logic [2:0]        col;
    logic [7:0]        sprite;
    logic              clip;
    logic              pix_en;

    logic [3:0]        row_nxt;
    logic [2:0]        col_sel;
    logic [6:0]        x_sum;
    logic [5:0]        y_sum;
    logic              clip_nxt;

    // Pixel address for the next PX_RD: column 0 when leaving LATCH, col+1 when
    // stepping along the row from PX_WR. The sums keep their carry so clipping
    // can be decided; the truncated low bits give the wrapped coordinate.
    always_comb begin
        row_nxt  = row + 4'd1;
        col_sel  = (state == StPxWr) ? (col + 3'd1) : 3'd0;
        x_sum    = {1'b0, x0} + {4'b0000, col_sel};
        y_sum    = {1'b0, y0} + {2'b00, row};
        clip_nxt = (WRAP == 0) && (x_sum[6] || y_sum[5]);
    end

    // The pixel read returns in the PX_WR cycle itself, so the write strobe and the
    // inverted value are formed from registered state and the live read data.
    assign fb_write = (state == StPxWr) && pix_en;
    assign fb_wdata = fb_write && !fb_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            fb_x      <= 6'd0;
            fb_y      <= 5'd0;
            x0        <= 6'd0;
            y0        <= 5'd0;
            rows      <= 4'd0;
            base      <= '0;
            row       <= 4'd0;
            col       <= 3'd0;
            sprite    <= 8'd0;
            clip      <= 1'b0;
            pix_en    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            done   <= 1'b0;
            mem_rd <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        collision <= 1'b0;
                        busy      <= 1'b1;
                        if (n != 4'd0) begin
                            x0       <= vx[5:0];
                            y0       <= vy[4:0];
                            rows     <= n;
                            base     <= i_addr;
                            row      <= 4'd0;
                            mem_rd   <= 1'b1;
                            mem_addr <= i_addr;
                            state    <= StFetch;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StFetch: begin
                    state <= StLatch;
                end
                StLatch: begin
                    sprite <= mem_rdata;
                    col    <= 3'd0;
                    fb_x   <= x_sum[5:0];
                    fb_y   <= y_sum[4:0];
                    clip   <= clip_nxt;
                    state  <= StPxRd;
                end
                StPxRd: begin
                    // ~col selects sprite bit 7-col (MSB is the leftmost pixel).
                    pix_en <= sprite[~col] && !clip;
                    state  <= StPxWr;
                end
                StPxWr: begin
                    collision <= collision | (pix_en & fb_rdata);
                    pix_en    <= 1'b0;
                    if (col != 3'd7) begin
                        col   <= col + 3'd1;
                        fb_x  <= x_sum[5:0];
                        fb_y  <= y_sum[4:0];
                        clip  <= clip_nxt;
                        state <= StPxRd;
                    end else if (row != rows - 4'd1) begin
                        row      <= row_nxt;
                        mem_rd   <= 1'b1;
                        mem_addr <= base + ADDR_W'(row_nxt);
                        state    <= StFetch;
                    end else begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
